// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the buffered PS/2 keyboard port: prefix bytes,
// status bit positions, default port addresses and the FIFO entry layout.
package ps2_kbd_pkg;

  localparam logic [7:0]  PFX_EXT       = 8'hE0;
  localparam logic [7:0]  PFX_BRK       = 8'hF0;

  localparam logic [15:0] DEF_DATA_PORT = 16'h0060;
  localparam logic [15:0] DEF_STAT_PORT = 16'h0064;

  localparam int          ENTRY_W       = 10;

  localparam int          ST_EMPTY      = 8;
  localparam int          ST_FULL       = 9;
  localparam int          ST_EXT        = 13;
  localparam int          ST_BRK        = 14;
  localparam int          ST_OVF        = 15;
  localparam int          CTL_FLUSH     = 0;
  localparam int          CTL_CLR_OVF   = 15;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic ext,
                                                    input logic brk,
                                                    input logic [7:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; a pop and push on the same
// edge both take effect, so a full FIFO can accept a push alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_C);
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard port on the CPU I/O bus: strobe edge detection, optional
// E0/F0 prefix folding, buffered scancodes, status/control and level IRQ.
module ps2_kbd_port
  import ps2_kbd_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter logic [15:0] DATA_PORT  = DEF_DATA_PORT,
  parameter logic [15:0] STAT_PORT  = DEF_STAT_PORT,
  parameter bit          FOLD_BREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_data_clk,
  input  logic [15:0] port_addr,
  input  logic [15:0] port_out,
  input  logic        port_bit,
  input  logic        port_clk,
  input  logic        port_read,
  output logic [15:0] port_in,
  output logic        kbd_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic               ps2_clk_r, port_clk_r, port_read_r;
  logic               ext_pend_r, brk_pend_r, ovf_r, irq_r;
  logic               ps2_edge_s, wr_edge_s, rd_edge_s;
  logic               data_sel_s, stat_sel_s, prefix_s;
  logic               flush_s, clr_ovf_s, push_s, pop_s, push_ok_s, ovf_set_s;
  logic               full_s, empty_s;
  logic [ENTRY_W-1:0] entry_s, head_s;
  logic [CW-1:0]      count_s, count_next_s;
  logic [15:0]        status_s;
  logic               unused_s;

  assign unused_s   = ^{port_bit, port_out[14:1]};

  assign ps2_edge_s = ps2_data_clk & ~ps2_clk_r;
  assign wr_edge_s  = port_clk & ~port_clk_r;
  assign rd_edge_s  = port_read & ~port_read_r;
  assign data_sel_s = (port_addr == DATA_PORT);
  assign stat_sel_s = (port_addr == STAT_PORT);
  assign prefix_s   = FOLD_BREAK && ((ps2_data == PFX_EXT) || (ps2_data == PFX_BRK));

  assign flush_s    = wr_edge_s & stat_sel_s & port_out[CTL_FLUSH];
  assign clr_ovf_s  = wr_edge_s & stat_sel_s & port_out[CTL_CLR_OVF];
  assign pop_s      = rd_edge_s & data_sel_s & ~empty_s;
  // a flush on the same edge swallows the incoming byte
  assign push_s     = ps2_edge_s & ~prefix_s & ~flush_s;
  assign push_ok_s  = push_s & (~full_s | pop_s);
  assign ovf_set_s  = push_s & full_s & ~pop_s;
  assign entry_s    = make_entry(ext_pend_r, brk_pend_r, ps2_data);
  assign kbd_irq    = irq_r;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (entry_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // occupancy after this edge, used to register the interrupt level
  always_comb begin
    count_next_s = count_s;
    if (flush_s) begin
      count_next_s = '0;
    end else if (push_ok_s && !pop_s) begin
      count_next_s = count_s + CW'(1'b1);
    end else if (pop_s && !push_ok_s) begin
      count_next_s = count_s - CW'(1'b1);
    end else begin
      count_next_s = count_s;
    end
  end

  // status word and read-data mux
  always_comb begin
    status_s           = '0;
    status_s[CW-1:0]   = count_s;
    status_s[ST_EMPTY] = empty_s;
    status_s[ST_FULL]  = full_s;
    status_s[ST_EXT]   = ext_pend_r;
    status_s[ST_BRK]   = brk_pend_r;
    status_s[ST_OVF]   = ovf_r;
    if (data_sel_s) begin
      port_in = empty_s ? 16'h0000 : {6'b000000, head_s};
    end else if (stat_sel_s) begin
      port_in = status_s;
    end else begin
      port_in = 16'h0000;
    end
  end

  // strobe history, prefix flags, sticky overflow and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk_r   <= 1'b0;
      port_clk_r  <= 1'b0;
      port_read_r <= 1'b0;
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      ovf_r       <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      ps2_clk_r   <= ps2_data_clk;
      port_clk_r  <= port_clk;
      port_read_r <= port_read;
      irq_r       <= (count_next_s != '0);
      if (flush_s) begin
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end else if (ps2_edge_s && FOLD_BREAK) begin
        if (ps2_data == PFX_EXT) begin
          ext_pend_r <= 1'b1;
        end else if (ps2_data == PFX_BRK) begin
          brk_pend_r <= 1'b1;
        end else begin
          ext_pend_r <= 1'b0;
          brk_pend_r <= 1'b0;
        end
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Scoreboard bench: two ports (prefix folding on and off) share stimulus;
// a queue-based reference model supplies expected reads and status words.
module tb_ps2_kbd_port;

  localparam int          DEPTH = 4;
  localparam logic [15:0] DATA  = 16'h0060;
  localparam logic [15:0] STAT  = 16'h0064;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_data_clk = 1'b0;
  logic [15:0] port_addr = 16'h0000;
  logic [15:0] port_out = 16'h0000;
  logic        port_bit = 1'b0;
  logic        port_clk = 1'b0;
  logic        port_read = 1'b0;
  logic [15:0] port_in_f, port_in_r;
  logic        irq_f, irq_r;

  always #5 clk = ~clk;

  ps2_kbd_port #(.DEPTH(DEPTH), .DATA_PORT(DATA), .STAT_PORT(STAT), .FOLD_BREAK(1'b1)) u_fold (
    .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk),
    .port_addr(port_addr), .port_out(port_out), .port_bit(port_bit), .port_clk(port_clk),
    .port_read(port_read), .port_in(port_in_f), .kbd_irq(irq_f));

  ps2_kbd_port #(.DEPTH(DEPTH), .DATA_PORT(DATA), .STAT_PORT(STAT), .FOLD_BREAK(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk),
    .port_addr(port_addr), .port_out(port_out), .port_bit(port_bit), .port_clk(port_clk),
    .port_read(port_read), .port_in(port_in_r), .kbd_irq(irq_r));

  // reference model: index 0 folds prefixes, index 1 stores raw bytes
  logic [9:0] fifo_m [2][$];
  bit         ext_m [2];
  bit         brk_m [2];
  bit         ovf_m [2];

  typedef struct packed {
    logic [15:0] p0;
    logic [15:0] p1;
    logic        i0;
    logic        i1;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  bit    mon_req = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic logic [15:0] model_port(input int m, input logic [15:0] addr);
    logic [15:0] s;
    int          n;
    n = fifo_m[m].size();
    s = 16'h0000;
    if (addr == DATA) begin
      if (n > 0) s = {6'b000000, fifo_m[m][0]};
    end else if (addr == STAT) begin
      s[7:0] = 8'(n);
      s[8]   = (n == 0);
      s[9]   = (n == DEPTH);
      s[13]  = ext_m[m];
      s[14]  = brk_m[m];
      s[15]  = ovf_m[m];
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      fifo_m[m].delete();
      ext_m[m] = 1'b0;
      brk_m[m] = 1'b0;
      ovf_m[m] = 1'b0;
    end
  endtask

  // one strobe edge: pop before push, flush discards, set beats clear
  task automatic model_edge(input int m, input bit fold, input bit ps2, input logic [7:0] b,
                            input bit rd, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wd);
    bit         flush, clr, have_push, set_now;
    logic [9:0] ent;
    flush     = wr && (addr == STAT) && wd[0];
    clr       = wr && (addr == STAT) && wd[15];
    have_push = 1'b0;
    set_now   = 1'b0;
    ent       = 10'h000;
    if (ps2) begin
      if (fold && b == 8'hE0) ext_m[m] = 1'b1;
      else if (fold && b == 8'hF0) brk_m[m] = 1'b1;
      else begin
        have_push = 1'b1;
        ent = {ext_m[m], brk_m[m], b};
        ext_m[m] = 1'b0;
        brk_m[m] = 1'b0;
      end
    end
    if (flush) begin
      fifo_m[m].delete();
      ext_m[m] = 1'b0;
      brk_m[m] = 1'b0;
    end else begin
      if (rd && addr == DATA && fifo_m[m].size() > 0) void'(fifo_m[m].pop_front());
      if (have_push) begin
        if (fifo_m[m].size() < DEPTH) fifo_m[m].push_back(ent);
        else set_now = 1'b1;
      end
    end
    if (set_now) ovf_m[m] = 1'b1;
    else if (clr) ovf_m[m] = 1'b0;
  endtask

  task automatic expect_now(input string nm, input logic [15:0] addr);
    exp_t e;
    e.p0 = model_port(0, addr);
    e.p1 = model_port(1, addr);
    e.i0 = (fifo_m[0].size() != 0);
    e.i1 = (fifo_m[1].size() != 0);
    exp_q.push_back(e);
    name_q.push_back(nm);
    mon_req = 1'b1;
  endtask

  // drive strobes (held for 'hold' cycles), check before and after the edge
  task automatic step(input string nm, input bit ps2, input logic [7:0] b, input bit rd,
                      input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                      input int hold);
    @(posedge clk); #2;
    port_addr = addr; port_out = wd; ps2_data = b;
    ps2_data_clk = ps2; port_read = rd; port_clk = wr;
    expect_now({nm, "/pre"}, addr);
    model_edge(0, 1'b1, ps2, b, rd, wr, addr, wd);
    model_edge(1, 1'b0, ps2, b, rd, wr, addr, wd);
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #2;
      mon_req = 1'b0;
    end
    @(posedge clk); #2;
    ps2_data_clk = 1'b0; port_read = 1'b0; port_clk = 1'b0;
    port_addr = STAT;
    expect_now({nm, "/stat"}, STAT);
    @(posedge clk); #2;
    mon_req = 1'b0;
  endtask

  task automatic push_byte(input string nm, input logic [7:0] b);
    step(nm, 1'b1, b, 1'b0, 1'b0, STAT, 16'h0000, 1);
  endtask

  task automatic read_data(input string nm);
    step(nm, 1'b0, 8'h00, 1'b1, 1'b0, DATA, 16'h0000, 1);
  endtask

  task automatic write_stat(input string nm, input logic [15:0] wd);
    step(nm, 1'b0, 8'h00, 1'b0, 1'b1, STAT, wd, 1);
  endtask

  task automatic cmp16(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, req);
    end
  endtask

  // monitor: pops one expectation per requested sample, on the falling edge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (mon_req) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard: sample requested, got empty queue, expected an entry");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          cmp16({nm, "/port_in_fold"}, port_in_f, e.p0);
          cmp16({nm, "/port_in_raw"}, port_in_r, e.p1);
          cmp16({nm, "/irq_fold"}, {15'h0000, irq_f}, {15'h0000, e.i0});
          cmp16({nm, "/irq_raw"}, {15'h0000, irq_r}, {15'h0000, e.i1});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [15:0] a, wd;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    step("rst_stat", 1'b0, 8'h00, 1'b0, 1'b0, STAT, 16'h0000, 1);
    step("rst_data", 1'b0, 8'h00, 1'b0, 1'b0, DATA, 16'h0000, 1);

    push_byte("push76", 8'h76);
    read_data("read76");
    read_data("read_empty");

    push_byte("pfx_e0", 8'hE0);
    push_byte("pfx_f0", 8'hF0);
    push_byte("pfx_75", 8'h75);
    for (int i = 0; i < 3; i++) read_data("pfx_read");

    for (int i = 1; i <= 5; i++) push_byte("fill", 8'(i));
    for (int i = 0; i < 4; i++) read_data("drain");
    write_stat("clr_ovf", 16'h8000);

    for (int i = 1; i <= 4; i++) push_byte("full", 8'(i));
    step("push_pop_full", 1'b1, 8'h05, 1'b1, 1'b0, DATA, 16'h0000, 1);
    step("ovf_set_clr", 1'b1, 8'h44, 1'b0, 1'b1, STAT, 16'h8000, 1);
    write_stat("flush", 16'h0001);
    step("push_pop_empty", 1'b1, 8'h2A, 1'b1, 1'b0, DATA, 16'h0000, 1);
    step("flush_push", 1'b1, 8'h33, 1'b0, 1'b1, STAT, 16'h8001, 1);
    push_byte("flush_pfx_e0", 8'hE0);
    step("flush_pfx", 1'b0, 8'h00, 1'b0, 1'b1, STAT, 16'h0001, 1);

    step("hold_push", 1'b1, 8'h12, 1'b0, 1'b0, STAT, 16'h0000, 3);
    push_byte("hold_push2", 8'h13);
    step("hold_read", 1'b0, 8'h00, 1'b1, 1'b0, DATA, 16'h0000, 3);
    step("data_write", 1'b0, 8'h00, 1'b0, 1'b1, DATA, 16'hFFFF, 1);
    step("other_addr", 1'b0, 8'h00, 1'b1, 1'b0, 16'h0123, 16'h0000, 1);
    write_stat("flush2", 16'h0001);

    // reset in the middle of a break sequence loses the pending prefix
    push_byte("pre_rst_f0", 8'hF0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    port_addr = STAT;
    expect_now("in_reset", STAT);
    @(posedge clk); #2;
    mon_req = 1'b0;
    rst_n = 1'b1;
    push_byte("post_rst_1c", 8'h1C);
    read_data("post_rst_read");

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = DATA;
        2:       a = STAT;
        default: a = 16'h0061;
      endcase
      wd = 16'($urandom_range(0, 65535));
      wd[0]  = ($urandom_range(0, 5) == 0);
      wd[15] = ($urandom_range(0, 3) == 0);
      step("rand", 1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), a, wd, int'($urandom_range(1, 2)));
    end

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_port.md
# ps2_kbd_port

Buffered PS/2 keyboard port peripheral on the CPU I/O port bus: accepts decoded scancode bytes with a strobe from the PS/2 receiver, optionally folds `E0`/`F0` prefixes into flag bits, queues entries in a parametrised FIFO, and exposes data and status registers to the CPU `IN`/`OUT` port interface. It replaces single-byte keyboard latching with lossless buffering, overflow reporting, flush control and a level interrupt request.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..128.
- `DATA_PORT`, 16'h0060: port address of the data register.
- `STAT_PORT`, 16'h0064: port address of the status/control register.
- `FOLD_BREAK`, 1: 1 = fold `E0`/`F0` prefixes into flags; 0 = store every byte raw.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_data`  in  8  received scancode byte, valid while strobe is high.
- `ps2_data_clk`  in  1  byte strobe; rising edge = one byte.
- `port_addr`  in  16  CPU port address.
- `port_out`  in  16  write data from CPU.
- `port_bit`  in  1  access width (1 = 16-bit); accepted, no effect on decode.
- `port_clk`  in  1  write strobe; rising edge = one write.
- `port_read`  in  1  read strobe; rising edge = one read.
- `port_in`  out  16  read data to CPU.
- `kbd_irq`  out  1  registered, high while FIFO non-empty.

## Operation
- Strobes `ps2_data_clk`, `port_clk`, `port_read` are edge-detected against a 1-cycle registered copy; a held level acts once.
- Entry format, 10 bits: `{ext, brk, code[7:0]}`; `port_in` for data read = `{6'b0, ext, brk, code}`.
- FOLD_BREAK=1: byte `E0` sets `ext_pend`, `F0` sets `brk_pend`, neither pushes; any other byte pushes `{ext_pend, brk_pend, byte}` and clears both pending flags.
- FOLD_BREAK=0: every byte pushes `{0, 0, byte}`; pending flags stay 0.
- Data read (edge with `port_addr==DATA_PORT`): pops head if non-empty; empty read returns 0, no pop.
- `port_in` is combinational: `DATA_PORT` -> head entry (0 if empty); `STAT_PORT` -> status; other addresses -> 0.
- Status: [7:0] count, [8] empty, [9] full, [13] `ext_pend`, [14] `brk_pend`, [15] sticky overflow; other bits 0.
- Status write: `port_out[0]`=1 flushes FIFO and pending flags; `port_out[15]`=1 clears overflow. Writes to `DATA_PORT` are ignored.
- Push while full with no same-cycle pop: entry dropped, overflow set.
- Push and pop in the same cycle: pop then push; when full, count unchanged and no overflow; when empty, the pop is an empty read and the push lands.
- Flush and push in the same cycle: flush wins and the entry is discarded. Overflow set and clear in the same cycle: set wins.
- Reset: FIFO empty, pointers 0, pending flags 0, overflow 0, `kbd_irq`=0, edge registers 0; status reads 0x0100.

## Timing
- Push/pop/flush take effect at the clock edge where the strobe edge is detected; count and status are visible the next cycle.
- `kbd_irq` = registered (count_next != 0): rises 1 cycle after the first push, falls 1 cycle after the last pop or flush.
- Latency from strobe rising edge to entry readable on `port_in`: 1 cycle.
- Reset asserted mid-stream: all state clears immediately; a pending `F0` is lost.

## Structure
- Package `ps2_kbd_pkg`: `PFX_EXT`=8'hE0, `PFX_BRK`=8'hF0, status bit indices, default port addresses, entry width 10.
- Sub-module `sync_fifo`: parameters `DEPTH` and `WIDTH`; ports `push`, `pop`, `flush`, `din`, `dout`, `count`, `full`, `empty`; wrap-around pointers and clog2(DEPTH)+1-bit count.
- Top level holds edge detectors, prefix folding, address decode, status and overflow logic.

## Test plan
- Reset -> status read 0x0100, data read 0x0000, `kbd_irq`=0.
- Byte 0x76 -> status 0x0001 and `kbd_irq`=1 next cycle; data read 0x0076; then status 0x0100 and `kbd_irq` low 1 cycle after the pop.
- FOLD_BREAK=1, bytes E0,F0,75 -> one entry, read 0x0375. FOLD_BREAK=0, same bytes -> reads 0x00E0, 0x00F0, 0x0075.
- DEPTH=4, bytes 01..05 -> status 0x8204; reads 01,02,03,04; write 0x8000 -> status 0x0100.
- DEPTH=4 full, push and data read on the same edge -> returns 01, count stays 4, bit 15 clear.
- Flush write with simultaneous push -> status 0x0100. F0 then reset then 1C -> read 0x001C.
